keypad_scanner_gen: RTL and testbench
=====================================

KEYPAD_SCANNER_GEN -- requirements
Module: keypad_scanner_gen

Interface
REQ-001 SHALL have parameter NROWS, default 4, number of keypad rows.
REQ-002 SHALL have parameter NCOLS, default 4, number of keypad columns.
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clock cycles each column is driven.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required for press or release.
REQ-005 SHALL have parameter REPEAT_EN, default 0, enables auto-repeat while held.
REQ-006 SHALL have parameter REPEAT_DELAY, default 500000, cycles from accept to first repeat.
REQ-007 SHALL have parameter REPEAT_PERIOD, default 200000, cycles between subsequent repeats.
REQ-008 SHALL have parameter HIST_DEPTH, default 2, number of accepted codes retained.
REQ-009 SHALL derive localparam CODE_W = $clog2(NROWS*NCOLS).
REQ-010 clk  input  1  single system clock.
REQ-011 reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-012 row  input  NROWS  asynchronous row sense lines, active-high.
REQ-013 col  output  NCOLS  one-hot column drive, active-high.
REQ-014 key_code  output  CODE_W  code of most recent accepted key, row_index*NCOLS+col_index.
REQ-015 key_valid  output  1  one-cycle pulse per accept or repeat.
REQ-016 key_repeat  output  1  high with key_valid when the pulse is a repeat.
REQ-017 key_held  output  1  high from accept until release is debounced.
REQ-018 hist  output  HIST_DEPTH*CODE_W  accepted codes, newest in bits [CODE_W-1:0].
REQ-019 hist_count  output  $clog2(HIST_DEPTH+1)  number of valid hist entries, saturating at HIST_DEPTH.

Function
REQ-020 SHALL pass row through a two-flop synchroniser; all decisions use the synchronised value rs.
REQ-021 SHALL implement states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-022 SCAN: col advances one bit every SCAN_DIV cycles, bit NCOLS-1 wraps to bit 0.
REQ-023 SCAN: on the last dwell cycle of a column, if rs != 0, SHALL latch that column index and the lowest set row index, freeze col and enter DEBOUNCE.
REQ-024 DEBOUNCE: the latched row bit high for DEBOUNCE_CYCLES consecutive cycles SHALL enter HELD; a low sample SHALL return to SCAN with col advancing to the next column.
REQ-025 On DEBOUNCE->HELD SHALL, in the same cycle: pulse key_valid, load key_code, set key_held, shift code into hist, increment hist_count (saturating).
REQ-026 HELD: col stays frozen; rows other than the latched row SHALL be ignored; no further accept until release.
REQ-027 HELD: latched row bit low SHALL enter RELEASE.
REQ-028 RELEASE: DEBOUNCE_CYCLES consecutive lows SHALL clear key_held and enter SCAN; any high SHALL return to HELD without key_valid.
REQ-029 With REPEAT_EN=1, key_valid and key_repeat SHALL pulse REPEAT_DELAY cycles after accept, then every REPEAT_PERIOD while in HELD; repeats SHALL NOT alter hist or hist_count.
REQ-030 Repeat timer SHALL pause in RELEASE and restart from zero on the next accept.
REQ-031 Debounce and repeat counters SHALL be wide enough for their parameter without wrap.

Reset
REQ-032 With reset=0 at a rising edge: state SCAN, col = 1 in bit 0, key_code=0, key_valid=0, key_repeat=0, key_held=0, hist=0, hist_count=0, all counters and synchroniser flops 0.
REQ-033 Reset SHALL take priority over every state, including mid-DEBOUNCE, HELD and RELEASE.

Verification (NROWS=NCOLS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=32, REPEAT_PERIOD=16, HIST_DEPTH=2)
REQ-034 row=0001 while col=0001 -> key_valid pulses once about 10 cycles after the last dwell cycle, key_code=0, key_held=1, col stays 0001.
REQ-035 row=0001 for 3 cycles, then 0000 -> no key_valid, col resumes rotation at 0010.
REQ-036 Key 5 (row=0010, col=0010) held, then row=0101, then row=0000 -> no additional key_valid, key_code=5, key_held falls 8 cycles after release, hist[3:0]=5.
REQ-037 REPEAT_EN=1, key 5 held 70 cycles after accept -> repeat pulses with key_repeat=1 at +32, +48, +64; hist_count unchanged.
REQ-038 Accept codes 0, 5, 15 in order -> hist={5,15} (15 in low bits), hist_count=2.
REQ-039 reset=0 for one edge while HELD -> all outputs at REQ-032 values on the next cycle; scanning restarts at col=0001.

Source files
------------

// File: rtl/keypad_scanner_gen.sv
// keypad_scanner_gen: scans an NROWS x NCOLS key matrix. It drives one column
// at a time and debounces a detected press. It then reports the key code, with
// optional auto-repeat, and keeps a short history of accepted codes.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset
//   row        asynchronous row sense lines, active-high
//   col        one-hot column drive, active-high
//   key_code   code of most recent accepted key (row*NCOLS + col)
//   key_valid  one-cycle pulse per accept or repeat
//   key_repeat high together with key_valid when the pulse is a repeat
//   key_held   high from accept until release is debounced
//   hist       accepted codes, newest in the low CODE_W bits
//   hist_count number of valid hist entries, saturating at HIST_DEPTH
module keypad_scanner_gen #(
    parameter int unsigned NROWS           = 4,
    parameter int unsigned NCOLS           = 4,
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 500000,
    parameter int unsigned REPEAT_PERIOD   = 200000,
    parameter int unsigned HIST_DEPTH      = 2,
    localparam int unsigned CODE_W         = $clog2(NROWS * NCOLS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NROWS-1:0]               row,
    output logic [NCOLS-1:0]               col,
    output logic [CODE_W-1:0]              key_code,
    output logic                           key_valid,
    output logic                           key_repeat,
    output logic                           key_held,
    output logic [HIST_DEPTH*CODE_W-1:0]   hist,
    output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count
);

    localparam int unsigned RIW     = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int unsigned DIV_W   = $clog2(SCAN_DIV + 1);
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam int unsigned HCW     = $clog2(HIST_DEPTH + 1);
    localparam int unsigned HW      = HIST_DEPTH * CODE_W;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [HCW-1:0]   HC_MAX       = HCW'(HIST_DEPTH);

    typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

    state_e             state;
    logic [NROWS-1:0]   rs_meta;
    logic [NROWS-1:0]   rs;
    logic [DIV_W-1:0]   div_cnt;
    logic [DEB_W-1:0]   deb_cnt;
    logic [REP_W-1:0]   rep_cnt;
    logic               rep_first;
    logic [RIW-1:0]     lat_row;
    logic [CODE_W-1:0]  lat_code;

    int unsigned        low_row;
    int unsigned        col_idx;
    logic [NCOLS-1:0]   col_next;
    logic [CODE_W-1:0]  code_calc;
    logic               row_bit;

    always_comb begin
        low_row = 0;
        // Descending scan so the lowest set row index wins.
        for (int i = int'(NROWS) - 1; i >= 0; i--) begin
            if (rs[i]) low_row = unsigned'(i);
        end
        col_idx = 0;
        for (int j = 0; j < int'(NCOLS); j++) begin
            if (col[j]) col_idx = unsigned'(j);
        end
        col_next  = (col << 1) | (col >> (NCOLS - 1));
        code_calc = CODE_W'(low_row * NCOLS + col_idx);
        row_bit   = rs[lat_row];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= StScan;
            rs_meta    <= '0;
            rs         <= '0;
            col        <= NCOLS'(1);
            div_cnt    <= '0;
            deb_cnt    <= '0;
            rep_cnt    <= '0;
            rep_first  <= 1'b0;
            lat_row    <= '0;
            lat_code   <= '0;
            key_code   <= '0;
            key_valid  <= 1'b0;
            key_repeat <= 1'b0;
            key_held   <= 1'b0;
            hist       <= '0;
            hist_count <= '0;
        end else begin
            rs_meta    <= row;
            rs         <= rs_meta;
            key_valid  <= 1'b0;
            key_repeat <= 1'b0;

            unique case (state)
                StScan: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (rs != '0) begin
                            // Freeze col on the candidate column.
                            lat_row  <= RIW'(low_row);
                            lat_code <= code_calc;
                            deb_cnt  <= '0;
                            state    <= StDebounce;
                        end else begin
                            col <= col_next;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                StDebounce: begin
                    if (row_bit) begin
                        if (deb_cnt == DEB_LAST) begin
                            key_valid  <= 1'b1;
                            key_code   <= lat_code;
                            key_held   <= 1'b1;
                            hist       <= (hist << CODE_W) | HW'(lat_code);
                            if (hist_count != HC_MAX) hist_count <= hist_count + HCW'(1);
                            rep_cnt    <= '0;
                            rep_first  <= 1'b1;
                            deb_cnt    <= '0;
                            state      <= StHeld;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        col     <= col_next;
                        div_cnt <= '0;
                        state   <= StScan;
                    end
                end

                StHeld: begin
                    if (!row_bit) begin
                        deb_cnt <= '0;
                        state   <= StRelease;
                    end else if (REPEAT_EN != 0) begin
                        // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
                        if ((rep_first && rep_cnt == REP_DLY_LAST) ||
                            (!rep_first && rep_cnt == REP_PER_LAST)) begin
                            key_valid  <= 1'b1;
                            key_repeat <= 1'b1;
                            rep_cnt    <= '0;
                            rep_first  <= 1'b0;
                        end else begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                        end
                    end
                end

                StRelease: begin
                    // Repeat timer is left untouched here so it pauses.
                    if (row_bit) begin
                        state <= StHeld;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_held <= 1'b0;
                        col      <= col_next;
                        div_cnt  <= '0;
                        state    <= StScan;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end

                default: state <= StScan;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner_gen.sv
// Bench for keypad_scanner_gen: a key-matrix model drives row from the pressed
// keys and the current col. Expected codes, repeat times and history are
// derived from key positions and hold times.
module tb_keypad_scanner_gen;
    localparam int NR = 4, NC = 4, SD = 4, DB = 8, RD = 32, RP = 16, HD = 2, CW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     row = '0;
    logic [NC-1:0]     col;
    logic [CW-1:0]     key_code;
    logic              key_valid, key_repeat, key_held;
    logic [HD*CW-1:0]  hist;
    logic [1:0]        hist_count;

    keypad_scanner_gen #(
        .NROWS(NR), .NCOLS(NC), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .HIST_DEPTH(HD)
    ) dut (
        .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_repeat(key_repeat), .key_held(key_held),
        .hist(hist), .hist_count(hist_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0, cyc = 0;
    bit raw_mode = 1'b0;
    logic [NR-1:0] row_raw = '0;
    bit pressed [NR][NC];
    int ev_cyc[$];
    int ev_code[$];
    bit ev_rep[$];
    int model_hist[$];  // newest first

    task automatic drive_row();
        logic [NR-1:0] r;
        r = '0;
        if (raw_mode) r = row_raw;
        else
            for (int ri = 0; ri < NR; ri++)
                for (int ci = 0; ci < NC; ci++)
                    if (pressed[ri][ci] && col[ci] === 1'b1) r[ri] = 1'b1;
        row = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (key_valid === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_code.push_back(int'(key_code));
            ev_rep.push_back(key_repeat === 1'b1);
        end
        drive_row();
    endtask

    task automatic clear_events();
        ev_cyc.delete(); ev_code.delete(); ev_rep.delete();
    endtask

    task automatic release_all();
        for (int ri = 0; ri < NR; ri++)
            for (int ci = 0; ci < NC; ci++) pressed[ri][ci] = 1'b0;
        drive_row();
    endtask

    task automatic press_wait_accept(input int r, input int c, output int acc, output bit ok);
        raw_mode = 1'b0;
        pressed[r][c] = 1'b1;
        drive_row();
        ok = 1'b0;
        acc = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (key_valid === 1'b1 && key_repeat !== 1'b1) begin ok = 1'b1; acc = cyc; end
        end
    endtask

    task automatic wait_held_low(output int fall, output bit ok);
        ok = 1'b0;
        fall = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            if (key_held === 1'b0) begin ok = 1'b1; fall = cyc; end
        end
    endtask

    // Wait for col to move 1000 -> 0001; returns the first dwell cycle of column 0.
    task automatic wait_col0_start(output int t0, output bit ok);
        logic [NC-1:0] prev;
        prev = col;
        ok = 1'b0;
        t0 = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (col === 4'b0001 && prev === 4'b1000) begin ok = 1'b1; t0 = cyc; end
            prev = col;
        end
    endtask

    function automatic logic [HD*CW-1:0] exp_hist();
        logic [HD*CW-1:0] v;
        v = '0;
        for (int i = 0; i < HD && i < model_hist.size(); i++) v[i*CW +: CW] = CW'(model_hist[i]);
        return v;
    endfunction

    function automatic int exp_count();
        return (model_hist.size() > HD) ? HD : model_hist.size();
    endfunction

    // True when a repeat would fall too close to the release for a clean prediction.
    function automatic bit ambiguous(input int h);
        for (int o = RD; o <= h + 10; o += RP) if (o >= h - 2 && o <= h + 4) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        n_checks++; if (col !== 4'b0001) $display("FAIL reset_col got %b want 0001", col); else n_pass++;
        n_checks++; if (key_code !== 4'd0) $display("FAIL reset_code got %0d want 0", key_code); else n_pass++;
        n_checks++; if (key_valid !== 1'b0 || key_repeat !== 1'b0)
            $display("FAIL reset_pulses got %b%b want 00", key_valid, key_repeat); else n_pass++;
        n_checks++; if (key_held !== 1'b0) $display("FAIL reset_held got %b want 0", key_held); else n_pass++;
        n_checks++; if (hist !== 8'h00 || hist_count !== 2'd0)
            $display("FAIL reset_hist got %h/%0d want 00/0", hist, hist_count); else n_pass++;
    endtask

    // Key 0 pressed at the start of column 0's dwell; the last dwell cycle is t0+SD-1,
    // DB high cycles follow in debounce, and key_valid is seen the cycle after that.
    task automatic test_single_press();
        int t0, acc, fall;
        bit ok;
        clear_events();
        wait_col0_start(t0, ok);
        n_checks++; if (!ok) $display("FAIL single_col_wrap got timeout want col 0001"); else n_pass++;
        press_wait_accept(0, 0, acc, ok);
        n_checks++; if (!ok) $display("FAIL single_accept got timeout want key_valid"); else n_pass++;
        n_checks++; if (acc - t0 !== SD + DB)
            $display("FAIL single_latency got %0d want %0d", acc - t0, SD + DB); else n_pass++;
        model_hist.push_front(0);
        n_checks++; if (key_code !== 4'd0 || key_held !== 1'b1)
            $display("FAIL single_code got %0d/%b want 0/1", key_code, key_held); else n_pass++;
        repeat (20) step();
        n_checks++; if (col !== 4'b0001) $display("FAIL single_col_frozen got %b want 0001", col); else n_pass++;
        n_checks++; if (ev_cyc.size() !== 1)
            $display("FAIL single_pulse_count got %0d want 1", ev_cyc.size()); else n_pass++;
        n_checks++; if (hist !== exp_hist() || hist_count !== 2'(exp_count()))
            $display("FAIL single_hist got %h/%0d want %h/%0d", hist, hist_count, exp_hist(),
                     exp_count()); else n_pass++;
        release_all();
        wait_held_low(fall, ok);
        n_checks++; if (!ok) $display("FAIL single_release got timeout want key_held 0"); else n_pass++;
        repeat (3) step();
    endtask

    task automatic test_glitch();
        int t0;
        bit ok, changed, seen2;
        logic [NC-1:0] first_new;
        clear_events();
        raw_mode = 1'b1;
        row_raw = '0;
        wait_col0_start(t0, ok);
        n_checks++; if (!ok) $display("FAIL glitch_col_wrap got timeout want col 0001"); else n_pass++;
        row_raw = 4'b0001;
        drive_row();
        repeat (3) step();
        row_raw = 4'b0000;
        drive_row();
        changed = 1'b0;
        seen2 = 1'b0;
        first_new = '0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (!changed && col !== 4'b0001) begin changed = 1'b1; first_new = col; end
            if (col === 4'b0100) seen2 = 1'b1;
        end
        n_checks++; if (ev_cyc.size() !== 0)
            $display("FAIL glitch_no_valid got %0d pulses want 0", ev_cyc.size()); else n_pass++;
        n_checks++; if (first_new !== 4'b0010 || !seen2)
            $display("FAIL glitch_resume got %b want 0010 then rotation", first_new); else n_pass++;
        raw_mode = 1'b0;
    endtask

    // Release of the latched row is seen 2 sync cycles later, 1 cycle to enter release,
    // then DB consecutive lows before key_held drops.
    task automatic test_held_others();
        int acc, fall, t;
        bit ok;
        clear_events();
        press_wait_accept(1, 1, acc, ok);
        n_checks++; if (!ok || key_code !== 4'd5)
            $display("FAIL others_accept got %0d want 5", key_code); else n_pass++;
        model_hist.push_front(5);
        raw_mode = 1'b1;
        row_raw = 4'b0111;
        drive_row();
        repeat (10) step();
        n_checks++; if (key_held !== 1'b1) $display("FAIL others_held got %b want 1", key_held); else n_pass++;
        row_raw = 4'b0101;
        drive_row();
        t = cyc;
        repeat (3) step();
        row_raw = 4'b0000;
        drive_row();
        wait_held_low(fall, ok);
        n_checks++; if (!ok || fall - t !== 3 + DB)
            $display("FAIL others_release_time got %0d want %0d", fall - t, 3 + DB); else n_pass++;
        n_checks++; if (ev_cyc.size() !== 1 || key_code !== 4'd5)
            $display("FAIL others_no_extra got %0d pulses code %0d want 1/5", ev_cyc.size(),
                     key_code); else n_pass++;
        n_checks++; if (hist[3:0] !== 4'd5) $display("FAIL others_hist got %0d want 5", hist[3:0]); else n_pass++;
        pressed[1][1] = 1'b0;
        raw_mode = 1'b0;
        drive_row();
        repeat (3) step();
    endtask

    task automatic hold_and_check(input string tag, input int r, input int c, input int h);
        int acc, fall, k;
        int exp_off[$];
        bit ok;
        clear_events();
        press_wait_accept(r, c, acc, ok);
        n_checks++; if (!ok || int'(key_code) !== r * NC + c)
            $display("FAIL %s_accept got %0d want %0d", tag, key_code, r * NC + c); else n_pass++;
        model_hist.push_front(r * NC + c);
        while (cyc < acc + h) step();
        release_all();
        wait_held_low(fall, ok);
        n_checks++; if (!ok) $display("FAIL %s_release got timeout want key_held 0", tag); else n_pass++;
        for (int o = RD; o <= h; o += RP) exp_off.push_back(o);
        k = 0;
        for (int i = 0; i < ev_cyc.size(); i++) begin
            if (ev_rep[i]) begin
                if (k < exp_off.size()) begin
                    n_checks++; if (ev_cyc[i] - acc !== exp_off[k] || ev_code[i] !== r * NC + c)
                        $display("FAIL %s_repeat_time got +%0d code %0d want +%0d code %0d", tag,
                                 ev_cyc[i] - acc, ev_code[i], exp_off[k], r * NC + c);
                    else n_pass++;
                end
                k++;
            end
        end
        n_checks++; if (k !== exp_off.size() || ev_cyc.size() !== k + 1)
            $display("FAIL %s_repeat_count got %0d/%0d want %0d/%0d", tag, k, ev_cyc.size(),
                     exp_off.size(), exp_off.size() + 1); else n_pass++;
        n_checks++; if (hist !== exp_hist() || hist_count !== 2'(exp_count()))
            $display("FAIL %s_hist got %h/%0d want %h/%0d", tag, hist, hist_count, exp_hist(),
                     exp_count()); else n_pass++;
        repeat (3) step();
    endtask

    task automatic test_repeat();
        hold_and_check("repeat", 1, 1, 70);
    endtask

    task automatic test_history();
        hold_and_check("hist0", 0, 0, 5);
        hold_and_check("hist5", 1, 1, 5);
        hold_and_check("hist15", 3, 3, 5);
        n_checks++; if (hist !== 8'h5F || hist_count !== 2'd2)
            $display("FAIL history_final got %h/%0d want 5f/2", hist, hist_count); else n_pass++;
    endtask

    task automatic test_random();
        int h;
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(7, 0)) step();
            h = $urandom_range(90, 10);
            while (ambiguous(h)) h = $urandom_range(90, 10);
            hold_and_check("random", $urandom_range(NR - 1, 0), $urandom_range(NC - 1, 0), h);
        end
    endtask

    task automatic test_reset_held();
        int acc;
        bit ok;
        press_wait_accept(1, 1, acc, ok);
        n_checks++; if (!ok) $display("FAIL rsthold_accept got timeout want key_valid"); else n_pass++;
        repeat (4) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        release_all();
        model_hist.delete();
        n_checks++; if (col !== 4'b0001 || key_code !== 4'd0 || key_held !== 1'b0 ||
                        key_valid !== 1'b0 || key_repeat !== 1'b0 || hist !== 8'h00 ||
                        hist_count !== 2'd0)
            $display("FAIL rsthold_outputs got col %b code %0d held %b v %b r %b hist %h cnt %0d want 0001/0/0/0/0/00/0",
                     col, key_code, key_held, key_valid, key_repeat, hist, hist_count);
        else n_pass++;
        repeat (SD - 1) step();
        n_checks++; if (col !== 4'b0001) $display("FAIL rsthold_dwell got %b want 0001", col); else n_pass++;
        step();
        n_checks++; if (col !== 4'b0010) $display("FAIL rsthold_advance got %b want 0010", col); else n_pass++;
    endtask

    initial begin
        for (int ri = 0; ri < NR; ri++)
            for (int ci = 0; ci < NC; ci++) pressed[ri][ci] = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_held_others();
        test_repeat();
        test_history();
        test_random();
        test_reset_held();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
